// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of the BaseRAM controller (m0 fetch, m1 load/store).
// Define SRAM_ARB_RR_EN for round-robin; otherwise m1 has fixed priority.
module sram_arbiter #(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_rw_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_be_n_i,
  output logic              m0_gnt_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_done_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_rw_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_be_n_i,
  output logic              m1_gnt_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_done_o,
  output logic              m1_err_o,
  output logic              ctl_start_o,
  output logic              ctl_rw_o,
  output logic [DATA_W-1:0] ctl_data_o,
  output logic [DATA_W/8-1:0] ctl_be_n_o,
  output logic [ADDR_W-1:0] ctl_addr_o,
  input  logic [DATA_W-1:0] ctl_data_i,
  input  logic              ctl_r_ready_i,
  input  logic              ctl_w_finish_i,
  input  logic              ctl_busy_i
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic [7:0] TO = TIMEOUT[7:0];

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic rr_q, rr_d;
  logic [7:0] wdog_q, wdog_d;
  logic rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [BE_W-1:0] be_q, be_d;
  logic start_q, start_d;
  logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic done0_q, done0_d, done1_q, done1_d;
  logic err0_q, err0_d, err1_q, err1_d;
  logic gnt0, gnt1, win, fin, fin_err;

  // win=1 selects m1
`ifdef SRAM_ARB_RR_EN
  assign win = m1_req_i & (~m0_req_i | ~rr_q);
`else
  assign win = m1_req_i;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    wdog_d  = wdog_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    start_d = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    fin     = 1'b0;
    fin_err = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((m0_req_i | m1_req_i) && !ctl_busy_i) begin
          owner_d = win;
          rw_d    = win ? m1_rw_i    : m0_rw_i;
          addr_d  = win ? m1_addr_i  : m0_addr_i;
          data_d  = win ? m1_wdata_i : m0_wdata_i;
          be_d    = win ? m1_be_n_i  : m0_be_n_i;
          gnt0    = ~win;
          gnt1    = win;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_d  = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rw_q && ctl_r_ready_i) begin
          fin = 1'b1;
          if (owner_q) rd1_d = ctl_data_i;
          else rd0_d = ctl_data_i;
        end else if (!rw_q && ctl_w_finish_i) begin
          fin = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
          if (TO != 8'd0 && wdog_d == TO) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end
        end
        if (fin) begin
          state_d = S_DONE;
          done0_d = ~owner_q;
          done1_d = owner_q;
          err0_d  = ~owner_q & fin_err;
          err1_d  = owner_q & fin_err;
        end
      end
      S_DONE: begin
        rr_d    = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      wdog_q  <= 8'd0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      start_q <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      wdog_q  <= wdog_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      start_q <= start_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
    end
  end

  // grant is the only combinational output; keep it quiet during reset
  assign m0_gnt_o    = gnt0 & ~rst_i;
  assign m1_gnt_o    = gnt1 & ~rst_i;
  assign m0_rdata_o  = rd0_q;
  assign m1_rdata_o  = rd1_q;
  assign m0_done_o   = done0_q;
  assign m1_done_o   = done1_q;
  assign m0_err_o    = err0_q;
  assign m1_err_o    = err1_q;
  assign ctl_start_o = start_q;
  assign ctl_rw_o    = rw_q;
  assign ctl_data_o  = data_q;
  assign ctl_be_n_o  = be_q;
  assign ctl_addr_o  = addr_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter with a behavioural sram_ctl model and done scoreboard.
// Build with or without SRAM_ARB_RR_EN; expected grant order follows the build.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic m0_req = 0, m0_rw = 0, m1_req = 0, m1_rw = 0;
  logic [23:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wd = 0, m1_wd = 0;
  logic [3:0] m0_be = 0, m1_be = 0;
  logic m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rd, m1_rd;
  logic c_start, c_rw;
  logic [31:0] c_data;
  logic [3:0] c_be;
  logic [23:0] c_addr;
  logic [31:0] c_rdat = 0;
  logic c_rr = 0, c_wf = 0, c_busy;

  sram_arbiter #(.ADDR_W(24), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_rw_i(m0_rw), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wd), .m0_be_n_i(m0_be), .m0_gnt_o(m0_gnt),
    .m0_rdata_o(m0_rd), .m0_done_o(m0_done), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_rw_i(m1_rw), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wd), .m1_be_n_i(m1_be), .m1_gnt_o(m1_gnt),
    .m1_rdata_o(m1_rd), .m1_done_o(m1_done), .m1_err_o(m1_err),
    .ctl_start_o(c_start), .ctl_rw_o(c_rw), .ctl_data_o(c_data),
    .ctl_be_n_o(c_be), .ctl_addr_o(c_addr), .ctl_data_i(c_rdat),
    .ctl_r_ready_i(c_rr), .ctl_w_finish_i(c_wf), .ctl_busy_i(c_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // sram_ctl model: fixed latency, byte-lane writes, optional silence
  logic [31:0] mem [256];
  int lat = 2;
  bit no_resp = 0;
  bit busy_force = 0;
  bit pend = 0;
  int cnt = 0;
  logic p_rw;
  logic [7:0] p_a;
  logic [31:0] p_d;
  logic [3:0] p_be;
  assign c_busy = pend | busy_force;

  function automatic logic [31:0] merge(input logic [31:0] o,
      input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (!be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    c_rr <= 1'b0;
    c_wf <= 1'b0;
    if (rst) begin
      pend <= 1'b0;
    end else if (c_start) begin
      if (!no_resp) begin
        pend <= 1'b1;
        cnt  <= lat;
        p_rw <= c_rw;
        p_a  <= c_addr[7:0];
        p_d  <= c_data;
        p_be <= c_be;
      end
    end else if (pend) begin
      if (cnt <= 1) begin
        pend <= 1'b0;
        if (p_rw) begin
          c_rr   <= 1'b1;
          c_rdat <= mem[p_a];
        end else begin
          mem[p_a] <= merge(mem[p_a], p_d, p_be);
          c_wf     <= 1'b1;
        end
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // scoreboard of expected completions
  typedef struct {
    bit m;
    bit rw;
    bit err;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  int cyc = 0;
  int start_cnt = 0, done_cnt = 0;
  int start_cyc = 0, done_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (c_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (m0_gnt | m1_gnt) chk("gnt_excl", 64'(m0_gnt & m1_gnt), 64'd0);
    if (m0_done | m1_done) begin
      done_cyc = cyc;
      if (q.size() == 0) begin
        chk("unexpected_done", {62'd0, m1_done, m0_done}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_owner", {62'd0, m1_done, m0_done},
            e.m ? 64'd2 : 64'd1);
        chk("done_err", 64'(m0_err | m1_err), 64'(e.err));
        if (e.rw && !e.err)
          chk("rdata", 64'(e.m ? m1_rd : m0_rd), 64'(e.data));
      end
      done_cnt++;
    end
  end

  task automatic drive(input bit m, input bit v, input bit rw,
      input logic [23:0] a, input logic [31:0] wd, input logic [3:0] be);
    if (m) begin
      m1_req = v; m1_rw = rw; m1_addr = a; m1_wd = wd; m1_be = be;
    end else begin
      m0_req = v; m0_rw = rw; m0_addr = a; m0_wd = wd; m0_be = be;
    end
  endtask

  task automatic txn(input bit m, input bit rw, input logic [23:0] a,
      input logic [31:0] wd, input logic [3:0] be, input bit eerr,
      input logic [31:0] ed, input int busy_cyc);
    int n;
    int d0, s0;
    exp_t e;
    e.m = m; e.rw = rw; e.err = eerr; e.data = ed;
    q.push_back(e);
    d0 = done_cnt;
    s0 = start_cnt;
    @(posedge clk); #1;
    if (busy_cyc > 0) busy_force = 1;
    drive(m, 1, rw, a, wd, be);
    if (busy_cyc > 0) begin
      logic g;
      g = 0;
      repeat (busy_cyc) begin
        @(negedge clk);
        g = g | m0_gnt | m1_gnt;
      end
      chk("busy_nogrant", 64'(g), 64'd0);
      @(posedge clk); #1;
      busy_force = 0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m ? m1_gnt : m0_gnt) && n < 50);
    chk("gnt", 64'(m ? m1_gnt : m0_gnt), 64'd1);
    @(posedge clk); #1;
    drive(m, 0, 0, 0, 0, 0);
    n = 0;
    while (done_cnt == d0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done_cnt - d0), 64'd1);
    chk("one_start", 64'(start_cnt - s0), 64'd1);
  endtask

  initial begin
    int n, d0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h30] = 32'hFFFFFFFF;

    // reset with both requests high: everything must stay 0
    m0_req = 1; m1_req = 1;
    repeat (3) @(negedge clk);
    chk("rst_m0", {29'd0, m0_gnt, m0_rd, m0_done, m0_err}, 64'd0);
    chk("rst_m1", {29'd0, m1_gnt, m1_rd, m1_done, m1_err}, 64'd0);
    chk("rst_ctl", {c_start, c_rw, c_data, c_be, c_addr}, 64'd0);
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
    rst = 0;

    txn(0, 1, 24'h10, 0, 4'h0, 0, 32'hDEADBEEF, 0);
    txn(1, 0, 24'h20, 32'h12345678, 4'b0000, 0, 0, 0);
    txn(1, 1, 24'h20, 0, 4'h0, 0, 32'h12345678, 0);
    chk("m0_rdata_hold", 64'(m0_rd), 64'hDEADBEEF);
    txn(1, 0, 24'h30, 32'hAAAA5555, 4'b1100, 0, 0, 0);
    txn(1, 1, 24'h30, 0, 4'h0, 0, 32'hFFFF5555, 0);
    txn(0, 1, 24'h20, 0, 4'h0, 0, 32'h12345678, 3);

    // simultaneous requests, four grants
    for (int i = 0; i < 4; i++) begin
      exp_t e;
`ifdef SRAM_ARB_RR_EN
      e.m = (i % 2 == 0);
`else
      e.m = 1;
`endif
      e.rw = 1; e.err = 0;
      e.data = e.m ? 32'hFFFF5555 : 32'hDEADBEEF;
      q.push_back(e);
    end
    d0 = done_cnt;
    @(posedge clk); #1;
    drive(0, 1, 1, 24'h10, 0, 0);
    drive(1, 1, 1, 24'h30, 0, 0);
    n = 0;
    begin
      int g;
      g = 0;
      while (g < 4 && n < 400) begin
        @(negedge clk);
        n++;
        if (m0_gnt | m1_gnt) g++;
      end
      chk("four_grants", 64'(g), 64'd4);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    n = 0;
    while (done_cnt - d0 < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("four_dones", 64'(done_cnt - d0), 64'd4);

    // watchdog abort: ISSUE + 8 WAIT cycles, then DONE
    no_resp = 1;
    txn(0, 1, 24'h10, 0, 4'h0, 1, 0, 0);
    chk("wdog_latency", 64'(done_cyc - start_cyc), 64'd9);
    no_resp = 0;
    txn(1, 1, 24'h20, 0, 4'h0, 0, 32'h12345678, 0);

    // reset while waiting: transaction dropped silently
    lat = 20;
    @(posedge clk); #1;
    drive(0, 1, 1, 24'h10, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m0_gnt && n < 50);
    chk("gnt_pre_rst", 64'(m0_gnt), 64'd1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("mid_rst_m0", {29'd0, m0_gnt, m0_rd, m0_done, m0_err}, 64'd0);
    chk("mid_rst_m1", {29'd0, m1_gnt, m1_rd, m1_done, m1_err}, 64'd0);
    chk("mid_rst_ctl", {c_start, c_rw, c_data, c_be, c_addr}, 64'd0);
    d0 = done_cnt;
    repeat (30) @(negedge clk);
    chk("no_done_after_rst", 64'(done_cnt - d0), 64'd0);
    lat = 2;
    txn(0, 1, 24'h10, 0, 4'h0, 0, 32'hDEADBEEF, 0);
    chk("queue_empty", 64'(q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
